// File: rtl/exu_mc.sv
// exu_mc: multi-cycle execute unit with a valid/ready handshake on both sides.
// Operand b is src2 or imm, selected by src_sel. The unit computes ALU, shift
// and compare operations in one cycle. An iterative multiply can be added.
// The result is held in an output register until the downstream side accepts it.
//
// Optional feature: define EXU_MC_MUL_EN to build the iterative multiplier
// (op 10) and its MUL state. Without it, op 10 returns 0 with latency 1 and
// busy is tied low.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (src1, src2, imm, src_sel, op)
//   out_valid / out_ready result handshake (result)
//   busy                  high while an iterative multiply is in progress
module exu_mc #(
  parameter int DATA_WIDTH    = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  src_sel,
  input  logic [3:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef EXU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef EXU_MC_MUL_EN
    MUL  = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] b;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] alu;
  logic                  accept;

  // A new request can enter in the same cycle that the held result is consumed.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    b     = src_sel ? imm : src2;
    shamt = b[SW-1:0];
    alu   = '0;
    case (op)
      OP_ADD:  alu = src1 + b;
      OP_SUB:  alu = src1 - b;
      OP_AND:  alu = src1 & b;
      OP_OR:   alu = src1 | b;
      OP_XOR:  alu = src1 ^ b;
      OP_SLT:  alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(b))};
      OP_SLTU: alu = {{(DATA_WIDTH-1){1'b0}}, (src1 < b)};
      OP_SLL:  alu = src1 << shamt;
      OP_SRL:  alu = src1 >> shamt;
      OP_SRA:  alu = $signed(src1) >>> shamt;
      default: alu = '0;
    endcase
  end

`ifdef EXU_MC_MUL_EN
  localparam int N  = DATA_WIDTH / MUL_STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0] ma, mb, acc, partial;
  logic [CW-1:0]         cnt;

  // ma is pre-shifted each step and mb is consumed from the LSB end.
  // The shift-and-add therefore only needs the low slice of mb.
  assign partial = ma * DATA_WIDTH'(mb[MUL_STEP_BITS-1:0]);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
`ifdef EXU_MC_MUL_EN
      busy      <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else if (accept) begin
`ifdef EXU_MC_MUL_EN
      if (op == OP_MUL) begin
        ma        <= src1;
        mb        <= b;
        acc       <= '0;
        cnt       <= '0;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        state     <= MUL;
      end else
`endif
      begin
        result    <= alu;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
`ifdef EXU_MC_MUL_EN
    else if (state == MUL) begin
      acc <= acc + partial;
      ma  <= ma << MUL_STEP_BITS;
      mb  <= mb >> MUL_STEP_BITS;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) begin
        result    <= acc + partial;
        out_valid <= 1'b1;
        busy      <= 1'b0;
        state     <= DONE;
      end
    end
`endif
  end

endmodule
